adder_la_sequencer: RTL and testbench
=====================================

ADDER_LA_SEQUENCER -- requirements
Module: adder_la_sequencer

Interface
REQ-001 SHALL have parameter SETTLE_CYCLES, default 2, run-low cycles before capture (legal 1..15).
REQ-002 SHALL have parameter WIDTH, default 32, operand/sum/count width.
REQ-003 SHALL have port wb_clk_i  in  1  single clock; all state on rising edge.
REQ-004 SHALL have port wb_rst_n  in  1  asynchronous active-low reset.
REQ-005 SHALL have port cmd_valid  in  1  host command request.
REQ-006 SHALL have port cmd_ready  out  1  sequencer can accept a command.
REQ-007 SHALL have port cmd_a, cmd_b  in  WIDTH  operands.
REQ-008 SHALL have port cmd_cycles  in  WIDTH  ring-oscillator run length, in clocks.
REQ-009 SHALL have port rsp_valid  out  1  result available.
REQ-010 SHALL have port rsp_ready  in  1  host accepts result.
REQ-011 SHALL have port rsp_sum, rsp_count  out  WIDTH  captured sum and oscillator count.
REQ-012 SHALL have port rsp_mismatch  out  1  captured sum differs from cmd_a+cmd_b.
REQ-013 SHALL have port adder_a, adder_b  out  WIDTH  operands driven toward the instrumented adder.
REQ-014 SHALL have port adder_load, adder_clr, adder_run  out  1 each  adder control strobes.
REQ-015 SHALL have port adder_sum, adder_count  in  WIDTH  adder result and oscillator count.

Function
REQ-016 SHALL use states IDLE, LOAD, CLEAR, RUN, SETTLE, CAPTURE, RESP.
REQ-017 cmd_ready SHALL be 1 only in IDLE; a command is accepted on an edge with cmd_valid&&cmd_ready, latching cmd_a, cmd_b, cmd_cycles, IDLE->LOAD.
REQ-018 LOAD: adder_a/adder_b = latched operands, adder_load=1 for exactly one cycle, ->CLEAR.
REQ-019 CLEAR: adder_clr=1 for exactly one cycle, ->RUN.
REQ-020 RUN: adder_run=1 for exactly N cycles, N = latched cmd_cycles, with N=0 treated as 1; ->SETTLE.
REQ-021 SETTLE: adder_run=0 for exactly SETTLE_CYCLES cycles, ->CAPTURE.
REQ-022 CAPTURE: one cycle; rsp_sum<=adder_sum, rsp_count<=adder_count on exit edge; ->RESP.
REQ-023 RESP: rsp_valid=1, rsp_* stable until edge with rsp_ready=1, then ->IDLE; cmd_ready rises on the following cycle.
REQ-024 rsp_valid SHALL first be 1 exactly N+SETTLE_CYCLES+3 edges after the accepting edge.
REQ-025 adder_a/adder_b SHALL hold the last loaded operands from LOAD until the next LOAD.
REQ-026 Strobes adder_load/adder_clr/adder_run SHALL never be 1 simultaneously.
REQ-027 Internal run counter SHALL be WIDTH bits, counting down, no wrap; N=2^WIDTH-1 SHALL run exactly that many cycles.
REQ-028 rsp_valid=1 and rsp_ready=1 in same cycle while cmd_valid=1: command not accepted until the cycle after return to IDLE.
REQ-029 Inputs cmd_* SHALL be ignored outside the accepting edge; changes mid-operation have no effect.

Reset
REQ-030 wb_rst_n=0 SHALL immediately force IDLE and drive cmd_ready=0, rsp_valid=0, rsp_mismatch=0, all adder_* outputs=0, rsp_sum=rsp_count=0, asynchronously.
REQ-031 After reset release, cmd_ready SHALL be 1 from the first edge; reset mid-operation SHALL abort without producing a response.

Configuration
REQ-032 With SUM_CHECK_EN defined, the block SHALL register cmd_a+cmd_b (mod 2^WIDTH) at acceptance and set rsp_mismatch = (captured sum != expected) alongside rsp_valid.
REQ-033 Without SUM_CHECK_EN, rsp_mismatch SHALL be constant 0 and no adder logic is instantiated.

Verification
REQ-034 a=3, b=5, cycles=4, adder_sum=8, adder_count=0x1234, rsp_ready=1 -> rsp_valid at edge 9 after accept, rsp_sum=8, rsp_count=0x1234, rsp_mismatch=0.
REQ-035 cycles=0 -> adder_run high exactly 1 cycle; rsp_valid at edge 6.
REQ-036 SUM_CHECK_EN, a=0xFFFFFFFF, b=1, adder_sum=0 -> mismatch=0; adder_sum=1 -> mismatch=1; without macro -> mismatch=0 both.
REQ-037 rsp_ready held 0 for 10 cycles -> rsp_valid and rsp_sum stable, cmd_ready=0, cmd_valid ignored throughout.
REQ-038 wb_rst_n pulsed low during RUN -> adder_run=0 and state IDLE without waiting for clock; no rsp_valid; next command completes normally.
REQ-039 Back-to-back commands with cmd_valid held 1 and rsp_ready=1 -> one-cycle IDLE gap, second LOAD shows new operands, strobes never overlap.

Source files
------------

// File: rtl/adder_la_sequencer.sv
// adder_la_sequencer: drives load/clear/run/settle/capture on an instrumented adder and returns sum and oscillator count.
// Defining SUM_CHECK_EN adds a registered cmd_a+cmd_b reference and the rsp_mismatch flag.
module adder_la_sequencer #(
    parameter int SETTLE_CYCLES = 2,
    parameter int WIDTH         = 32
) (
    input  logic             wb_clk_i,
    input  logic             wb_rst_n,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [WIDTH-1:0] cmd_a,
    input  logic [WIDTH-1:0] cmd_b,
    input  logic [WIDTH-1:0] cmd_cycles,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH-1:0] rsp_sum,
    output logic [WIDTH-1:0] rsp_count,
    output logic             rsp_mismatch,
    output logic [WIDTH-1:0] adder_a,
    output logic [WIDTH-1:0] adder_b,
    output logic             adder_load,
    output logic             adder_clr,
    output logic             adder_run,
    input  logic [WIDTH-1:0] adder_sum,
    input  logic [WIDTH-1:0] adder_count
);
    typedef enum logic [2:0] {IDLE, LOAD, CLEAR, RUN, SETTLE, CAPTURE, RESP} state_t;
    state_t state, state_nx;
    logic armed;
    logic accept;
    logic last;
    logic [WIDTH-1:0] cnt;
    assign accept = cmd_valid && cmd_ready;
    assign last = cnt == WIDTH'(1);
    // armed keeps cmd_ready low until the first edge after reset release
    always_ff @(posedge wb_clk_i or negedge wb_rst_n) begin
        if (!wb_rst_n) begin
            state <= IDLE;
            armed <= 1'b0;
        end else begin
            state <= state_nx;
            armed <= 1'b1;
        end
    end
    always_comb begin
        state_nx   = state;
        cmd_ready  = 1'b0;
        rsp_valid  = 1'b0;
        adder_load = 1'b0;
        adder_clr  = 1'b0;
        adder_run  = 1'b0;
        case (state)
            IDLE: begin
                cmd_ready = armed;
                state_nx  = (cmd_valid && armed) ? LOAD : IDLE;
            end
            LOAD: begin
                adder_load = 1'b1;
                state_nx   = CLEAR;
            end
            CLEAR: begin
                adder_clr = 1'b1;
                state_nx  = RUN;
            end
            RUN: begin
                adder_run = 1'b1;
                state_nx  = last ? SETTLE : RUN;
            end
            SETTLE:  state_nx = last ? CAPTURE : SETTLE;
            CAPTURE: state_nx = RESP;
            RESP: begin
                rsp_valid = 1'b1;
                state_nx  = rsp_ready ? IDLE : RESP;
            end
            default: state_nx = IDLE;
        endcase
    end
    // one down-counter serves both the run length and the settle window
    always_ff @(posedge wb_clk_i or negedge wb_rst_n) begin
        if (!wb_rst_n) begin
            cnt       <= '0;
            adder_a   <= '0;
            adder_b   <= '0;
            rsp_sum   <= '0;
            rsp_count <= '0;
        end else begin
            if (accept) begin
                adder_a <= cmd_a;
                adder_b <= cmd_b;
                cnt     <= (cmd_cycles == '0) ? WIDTH'(1) : cmd_cycles;
            end else if ((state == RUN || state == SETTLE) && !last)
                cnt <= cnt - WIDTH'(1);
            else if (state == RUN)
                cnt <= WIDTH'(SETTLE_CYCLES);
            if (state == CAPTURE) begin
                rsp_sum   <= adder_sum;
                rsp_count <= adder_count;
            end
        end
    end
`ifdef SUM_CHECK_EN
    logic [WIDTH-1:0] sum_exp;
    logic mism;
    always_ff @(posedge wb_clk_i or negedge wb_rst_n) begin
        if (!wb_rst_n) begin
            sum_exp <= '0;
            mism    <= 1'b0;
        end else begin
            if (accept) sum_exp <= cmd_a + cmd_b;
            if (state == CAPTURE) mism <= adder_sum != sum_exp;
        end
    end
    assign rsp_mismatch = (state == RESP) && mism;
`else
    assign rsp_mismatch = 1'b0;
`endif
endmodule

// File: tb/tb_adder_la_sequencer.sv
// tb_adder_la_sequencer: randomized self-checking bench; the reference model derives latency, run length and mismatch from the command.
module tb_adder_la_sequencer;
    localparam int W = 32;
    localparam int S = 2;
    logic wb_clk_i = 1'b0, wb_rst_n = 1'b0, cmd_valid = 1'b0, rsp_ready = 1'b0;
    logic [W-1:0] cmd_a = '0, cmd_b = '0, cmd_cycles = '0, adder_sum = '0, adder_count = '0;
    logic cmd_ready, rsp_valid, rsp_mismatch, adder_load, adder_clr, adder_run;
    logic [W-1:0] rsp_sum, rsp_count, adder_a, adder_b;
    int checks = 0, errors = 0;

    adder_la_sequencer #(.SETTLE_CYCLES(S), .WIDTH(W)) dut (
        .wb_clk_i(wb_clk_i), .wb_rst_n(wb_rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_cycles(cmd_cycles), .rsp_valid(rsp_valid),
        .rsp_ready(rsp_ready), .rsp_sum(rsp_sum), .rsp_count(rsp_count), .rsp_mismatch(rsp_mismatch),
        .adder_a(adder_a), .adder_b(adder_b), .adder_load(adder_load), .adder_clr(adder_clr),
        .adder_run(adder_run), .adder_sum(adder_sum), .adder_count(adder_count)
    );

    always #5 wb_clk_i = ~wb_clk_i;

    function automatic int run_len(input logic [W-1:0] n);
        return (n == '0) ? 1 : int'(n);
    endfunction

    function automatic logic exp_mismatch(input logic [W-1:0] a, input logic [W-1:0] b, input logic [W-1:0] s);
        logic [W-1:0] t;
        t = a + b;
`ifdef SUM_CHECK_EN
        return s != t;
`else
        return 1'b0;
`endif
    endfunction

    task automatic test_reset();
        #3;
        checks++;
        if ({cmd_ready, rsp_valid, rsp_mismatch, adder_load, adder_clr, adder_run} !== 6'b0) begin
            errors++;
            $display("FAIL reset_ctrl: got %b want 000000", {cmd_ready, rsp_valid, rsp_mismatch, adder_load, adder_clr, adder_run});
        end
        checks++;
        if ({adder_a, adder_b, rsp_sum, rsp_count} !== '0) begin
            errors++;
            $display("FAIL reset_data: got %h %h %h %h want all 0", adder_a, adder_b, rsp_sum, rsp_count);
        end
        @(negedge wb_clk_i);
        wb_rst_n = 1'b1;
        @(negedge wb_clk_i);
        checks++;
        if (cmd_ready !== 1'b1) begin
            errors++;
            $display("FAIL ready_after_reset: got %b want 1", cmd_ready);
        end
    endtask

    task automatic do_cmd(input logic [W-1:0] a, input logic [W-1:0] b, input logic [W-1:0] n,
                          input logic [W-1:0] s, input logic [W-1:0] c, input int hold);
        int lat, runs, loads, clrs, over, busy, first, unstable;
        lat = run_len(n) + S + 3;
        runs = 0; loads = 0; clrs = 0; over = 0; busy = 0; first = -1; unstable = 0;
        @(negedge wb_clk_i);
        checks++;
        if (cmd_ready !== 1'b1) begin
            errors++;
            $display("FAIL cmd_ready_idle: got %b want 1", cmd_ready);
        end
        cmd_valid = 1'b1; cmd_a = a; cmd_b = b; cmd_cycles = n;
        adder_sum = s; adder_count = c; rsp_ready = 1'b0;
        for (int j = 0; j < lat + 20 && first < 0; j++) begin
            @(negedge wb_clk_i);
            if (j == 0) begin
                checks++;
                if (adder_load !== 1'b1 || adder_a !== a || adder_b !== b) begin
                    errors++;
                    $display("FAIL load_ops: got load=%b a=%h b=%h want 1 %h %h", adder_load, adder_a, adder_b, a, b);
                end
            end
            runs += int'(adder_run); loads += int'(adder_load); clrs += int'(adder_clr);
            if (int'(adder_load) + int'(adder_clr) + int'(adder_run) > 1) over++;
            busy += int'(cmd_ready);
            if (rsp_valid === 1'b1) first = j;
            cmd_valid = 1'($urandom_range(0, 1)); cmd_a = $urandom; cmd_b = $urandom; cmd_cycles = $urandom;
        end
        checks++;
        if (first != lat) begin
            errors++;
            $display("FAIL rsp_latency: got %0d want %0d", first, lat);
        end
        checks++;
        if (runs != run_len(n) || loads != 1 || clrs != 1 || over != 0) begin
            errors++;
            $display("FAIL strobes: got run=%0d load=%0d clr=%0d overlap=%0d want %0d 1 1 0", runs, loads, clrs, over, run_len(n));
        end
        checks++;
        if (busy != 0) begin
            errors++;
            $display("FAIL busy_ready: got %0d ready cycles want 0", busy);
        end
        checks++;
        if (rsp_sum !== s || rsp_count !== c || rsp_mismatch !== exp_mismatch(a, b, s)) begin
            errors++;
            $display("FAIL rsp_data: got %h %h %b want %h %h %b", rsp_sum, rsp_count, rsp_mismatch, s, c, exp_mismatch(a, b, s));
        end
        checks++;
        if (adder_a !== a || adder_b !== b) begin
            errors++;
            $display("FAIL ops_hold: got %h %h want %h %h", adder_a, adder_b, a, b);
        end
        for (int k = 0; k < hold; k++) begin
            @(negedge wb_clk_i);
            if (rsp_valid !== 1'b1 || rsp_sum !== s || rsp_count !== c || cmd_ready !== 1'b0) unstable++;
            cmd_valid = 1'($urandom_range(0, 1)); cmd_a = $urandom;
        end
        if (hold > 0) begin
            checks++;
            if (unstable != 0) begin
                errors++;
                $display("FAIL rsp_hold: got %0d unstable cycles want 0", unstable);
            end
        end
        cmd_valid = 1'b0; rsp_ready = 1'b1;
        @(negedge wb_clk_i);
        rsp_ready = 1'b0;
        checks++;
        if (rsp_valid !== 1'b0 || cmd_ready !== 1'b1) begin
            errors++;
            $display("FAIL rsp_release: got valid=%b ready=%b want 0 1", rsp_valid, cmd_ready);
        end
    endtask

    task automatic test_back_to_back();
        logic [W-1:0] a1, b1, a2, b2, n1, n2, s1, s2;
        int l1, l2, over, valids;
        a1 = $urandom; b1 = $urandom; a2 = $urandom; b2 = $urandom;
        n1 = W'($urandom_range(0, 6)); n2 = W'($urandom_range(0, 6));
        s1 = $urandom; s2 = $urandom;
        l1 = run_len(n1) + S + 3; l2 = run_len(n2) + S + 3;
        over = 0; valids = 0;
        @(negedge wb_clk_i);
        cmd_valid = 1'b1; rsp_ready = 1'b1; cmd_a = a1; cmd_b = b1; cmd_cycles = n1; adder_sum = s1;
        for (int j = 0; j <= l1 + 2 + l2; j++) begin
            @(negedge wb_clk_i);
            if (int'(adder_load) + int'(adder_clr) + int'(adder_run) > 1) over++;
            valids += int'(rsp_valid);
            if (j == l1) begin
                checks++;
                if (rsp_valid !== 1'b1 || rsp_sum !== s1) begin
                    errors++;
                    $display("FAIL b2b_rsp1: got %b %h want 1 %h", rsp_valid, rsp_sum, s1);
                end
                cmd_a = a2; cmd_b = b2; cmd_cycles = n2; adder_sum = s2;
            end
            if (j == l1 + 1) begin
                checks++;
                if (rsp_valid !== 1'b0 || cmd_ready !== 1'b1 || adder_load !== 1'b0) begin
                    errors++;
                    $display("FAIL b2b_gap: got valid=%b ready=%b load=%b want 0 1 0", rsp_valid, cmd_ready, adder_load);
                end
            end
            if (j == l1 + 2) begin
                checks++;
                if (adder_load !== 1'b1 || adder_a !== a2 || adder_b !== b2) begin
                    errors++;
                    $display("FAIL b2b_load2: got %b %h %h want 1 %h %h", adder_load, adder_a, adder_b, a2, b2);
                end
            end
            if (j == l1 + 2 + l2) begin
                checks++;
                if (rsp_valid !== 1'b1 || rsp_sum !== s2) begin
                    errors++;
                    $display("FAIL b2b_rsp2: got %b %h want 1 %h", rsp_valid, rsp_sum, s2);
                end
                cmd_valid = 1'b0;
            end
        end
        checks++;
        if (over != 0 || valids != 2) begin
            errors++;
            $display("FAIL b2b_strobes: got overlap=%0d valids=%0d want 0 2", over, valids);
        end
        @(negedge wb_clk_i);
        rsp_ready = 1'b0;
    endtask

    task automatic test_abort();
        int seen;
        seen = 0;
        @(negedge wb_clk_i);
        cmd_valid = 1'b1; cmd_a = $urandom; cmd_b = $urandom; cmd_cycles = W'(10); rsp_ready = 1'b1;
        @(negedge wb_clk_i);
        cmd_valid = 1'b0;
        repeat (2) @(negedge wb_clk_i);
        checks++;
        if (adder_run !== 1'b1) begin
            errors++;
            $display("FAIL abort_in_run: got %b want 1", adder_run);
        end
        #2 wb_rst_n = 1'b0;
        #1;
        checks++;
        if ({adder_run, cmd_ready, rsp_valid, adder_a} !== '0) begin
            errors++;
            $display("FAIL abort_async: got run=%b ready=%b valid=%b a=%h want all 0", adder_run, cmd_ready, rsp_valid, adder_a);
        end
        @(negedge wb_clk_i);
        wb_rst_n = 1'b1;
        repeat (25) begin
            @(negedge wb_clk_i);
            seen += int'(rsp_valid);
        end
        checks++;
        if (seen != 0 || cmd_ready !== 1'b1) begin
            errors++;
            $display("FAIL abort_no_rsp: got valids=%0d ready=%b want 0 1", seen, cmd_ready);
        end
        rsp_ready = 1'b0;
    endtask

    task automatic test_random();
        logic [W-1:0] a, b, s;
        for (int i = 0; i < 8; i++) begin
            a = $urandom; b = $urandom;
            s = $urandom_range(0, 1) ? a + b : W'($urandom);
            do_cmd(a, b, W'($urandom_range(0, 12)), s, W'($urandom), $urandom_range(0, 3));
        end
    endtask

    initial begin
        test_reset();
        do_cmd(32'd3, 32'd5, 32'd4, 32'd8, 32'h1234, 0);
        do_cmd($urandom, $urandom, 32'd0, $urandom, $urandom, 0);
        do_cmd(32'hFFFF_FFFF, 32'd1, 32'd1, 32'd0, 32'd7, 0);
        do_cmd(32'hFFFF_FFFF, 32'd1, 32'd2, 32'd1, 32'd9, 0);
        do_cmd($urandom, $urandom, 32'd3, $urandom, $urandom, 10);
        test_back_to_back();
        test_abort();
        do_cmd(32'd11, 32'd22, 32'd5, 32'd33, 32'hBEEF, 1);
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
